// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit pipelined CPU:
//   - opcode encodings OP_NOP..OP_BR
//   - bit positions of the 16-bit instruction word fields
//   - decoded-instruction struct and decode helper
//   - register-use helpers writes_rd / reads_rs1 / reads_rs2
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;
  localparam logic [2:0] OP_BR  = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 7;
  localparam int RSV_BIT = 6;
  localparam int TGT_MSB = 5;
  localparam int TGT_LSB = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [5:0] tgt;
  } dec_t;

  // Split an instruction word into its fields; the reserved bit is dropped.
  function automatic dec_t decode(input logic [15:0] word);
    dec_t d;
    d.op  = word[OPC_MSB:OPC_LSB];
    d.rd  = word[RD_MSB:RD_LSB];
    d.rs1 = word[RS1_MSB:RS1_LSB];
    d.rs2 = word[RS2_MSB:RS2_LSB];
    d.tgt = word[TGT_MSB:TGT_LSB];
    return d;
  endfunction

  // Every opcode except NOP and BR produces a register result.
  function automatic logic writes_rd(input logic [2:0] op);
    case (op)
      OP_NOP, OP_BR: return 1'b0;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic reads_rs1(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_OR, OP_EQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // NOT is the only ALU op with a single source.
  function automatic logic reads_rs2(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EQ: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 4 x 8-bit register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear of every entry.
// Ports:
//   i_clk, i_rst_n        clock / async active-low clear
//   i_we, i_waddr, i_wdata write port (sampled on rising edge)
//   i_raddr1/o_rdata1     read port 1 (combinational)
//   i_raddr2/o_rdata2     read port 2 (combinational)
// -----------------------------------------------------------------------------
module reg_file (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr1,
  input  logic [1:0] i_raddr2,
  output logic [7:0] o_rdata1,
  output logic [7:0] o_rdata2
);

  logic [7:0] r_mem [4];

  // Register storage with async clear and single write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_mem[i_waddr] <= r_mem[i_waddr];
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
// Decode/issue stage of the 8-bit CPU. Owns the 6-bit PC and the register
// file, decodes one 16-bit word per cycle into registered ALU inputs, writes
// back ALU results, forwards the in-flight result, interlocks distance-1
// dependences and resolves branches one edge after BR issues.
// Ports:
//   CLK, RST_N            clock / async active-low reset
//   imem_addr             instruction address (= PC)
//   imem_data, imem_valid instruction word and its valid flag
//   alu_out               registered ALU result of the previously issued op
//   branch_flag           ALU branch indicator (monitor only)
//   A, B, instr           registered operands and opcode to the ALU
//   branch_addr           registered branch target to the ALU
// -----------------------------------------------------------------------------
module decode_issue
  import cpu_pkg::*;
#(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [5:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic [7:0]  alu_out,
  input  logic        branch_flag,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  instr,
  output logic [5:0]  branch_addr
);

  logic [5:0] r_pc;
  logic [2:0] r_instr;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [5:0] r_br_addr;
  logic [1:0] r_iss_rd;
  logic [2:0] r_prv_op;
  logic [1:0] r_prv_rd;

  dec_t       w_dec;
  logic [7:0] w_rf_rd1;
  logic [7:0] w_rf_rd2;
  logic [7:0] w_opa;
  logic [7:0] w_opb;
  logic       w_wb_en;
  logic       w_hazard;
  logic       w_resolve;
  logic       w_taken;
  logic       w_issue;
  logic       w_unused;

  assign w_dec   = decode(imem_data);
  assign w_wb_en = writes_rd(r_prv_op);

  // The ALU flag and reserved instruction bit carry no meaning for this stage.
  assign w_unused = branch_flag ^ imem_data[RSV_BIT];

  reg_file u_rf (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_we     (w_wb_en),
    .i_waddr  (r_prv_rd),
    .i_wdata  (alu_out),
    .i_raddr1 (w_dec.rs1),
    .i_raddr2 (w_dec.rs2),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2)
  );

  // Operand select: the result on alu_out is newer than rf (its writeback is
  // this same edge), so it wins on a match. Unread operands are driven 0.
  always_comb begin
    w_opa = 8'd0;
    w_opb = 8'd0;
    if (reads_rs1(w_dec.op)) begin
      if (w_wb_en && (w_dec.rs1 == r_prv_rd)) begin
        w_opa = alu_out;
      end else begin
        w_opa = w_rf_rd1;
      end
    end else begin
      w_opa = 8'd0;
    end
    if (reads_rs2(w_dec.op)) begin
      if (w_wb_en && (w_dec.rs2 == r_prv_rd)) begin
        w_opb = alu_out;
      end else begin
        w_opb = w_rf_rd2;
      end
    end else begin
      w_opb = 8'd0;
    end
  end

  // Distance-1 dependence: the producer's result is not on alu_out yet.
  assign w_hazard = writes_rd(r_instr) &&
                    ((reads_rs1(w_dec.op) && (w_dec.rs1 == r_iss_rd)) ||
                     (reads_rs2(w_dec.op) && (w_dec.rs2 == r_iss_rd)));

  // While BR sits in instr, alu_out holds the result of the op before it.
  assign w_resolve = (r_instr == OP_BR);
  assign w_taken   = (r_prv_op == OP_EQ) && alu_out[0];
  assign w_issue   = !w_resolve && imem_valid && !w_hazard;

  // Issue registers, delay-slot tracking and PC update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc      <= RESET_PC;
      r_instr   <= OP_NOP;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_br_addr <= 6'd0;
      r_iss_rd  <= 2'd0;
      r_prv_op  <= OP_NOP;
      r_prv_rd  <= 2'd0;
    end else begin
      r_prv_op <= r_instr;
      r_prv_rd <= r_iss_rd;
      if (w_issue) begin
        r_instr   <= w_dec.op;
        r_a       <= w_opa;
        r_b       <= w_opb;
        r_br_addr <= (w_dec.op == OP_BR) ? w_dec.tgt : 6'd0;
        r_iss_rd  <= writes_rd(w_dec.op) ? w_dec.rd : 2'd0;
        r_pc      <= r_pc + 6'd1;
      end else begin
        r_instr   <= OP_NOP;
        r_a       <= 8'd0;
        r_b       <= 8'd0;
        r_br_addr <= 6'd0;
        r_iss_rd  <= 2'd0;
        // Not-taken BR leaves the PC already pointing past the branch.
        if (w_resolve && w_taken) begin
          r_pc <= r_br_addr;
        end else begin
          r_pc <= r_pc;
        end
      end
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign A           = r_a;
  assign B           = r_b;
  assign branch_addr = r_br_addr;

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
// Drives decode_issue from a 64-word program memory and a registered ALU stub.
// An instruction-level model (sequential register semantics, control rules for
// stall / interlock / branch) predicts imem_addr and the issue outputs for
// every cycle; hand-computed literals pin key cycles of each program.
// -----------------------------------------------------------------------------
module tb_decode_issue;

  localparam logic [2:0] K_NOP = 3'd0;
  localparam logic [2:0] K_ADD = 3'd1;
  localparam logic [2:0] K_SUB = 3'd2;
  localparam logic [2:0] K_AND = 3'd3;
  localparam logic [2:0] K_NOT = 3'd4;
  localparam logic [2:0] K_OR  = 3'd5;
  localparam logic [2:0] K_EQ  = 3'd6;
  localparam logic [2:0] K_BR  = 3'd7;

  logic        CLK;
  logic        RST_N;
  logic [5:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [7:0]  alu_out;
  logic        branch_flag;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  instr;
  logic [5:0]  branch_addr;

  logic [15:0] mem [64];
  int          n_chk;
  int          n_err;
  logic        chk_en;

  decode_issue #(.RESET_PC(6'd0)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .alu_out     (alu_out),
    .branch_flag (branch_flag),
    .A           (A),
    .B           (B),
    .instr       (instr),
    .branch_addr (branch_addr)
  );

  assign imem_data = mem[imem_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      K_ADD:   return a + b;
      K_SUB:   return a - b;
      K_AND:   return a & b;
      K_OR:    return a | b;
      K_NOT:   return ~a;
      K_EQ:    return (a == b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Registered ALU downstream of the stage.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_out     <= 8'd0;
      branch_flag <= 1'b0;
    end else begin
      alu_out     <= alu_f(instr, A, B);
      branch_flag <= (instr == K_BR);
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] s1, input logic [1:0] s2, input logic [5:0] t);
    return {op, rd, s1, s2, 1'b0, t};
  endfunction

  function automatic logic op_writes(input logic [2:0] op);
    return (op != K_NOP) && (op != K_BR);
  endfunction
  function automatic logic op_reads1(input logic [2:0] op);
    return (op != K_NOP) && (op != K_BR);
  endfunction
  function automatic logic op_reads2(input logic [2:0] op);
    return (op != K_NOP) && (op != K_BR) && (op != K_NOT);
  endfunction

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [5:0] tgt;
    logic [7:0] res;
  } iss_t;

  logic [5:0] m_pc;
  logic [7:0] m_rf [4];
  iss_t       m_last;
  iss_t       m_prev;
  logic [2:0] e_instr;
  logic [7:0] e_a;
  logic [7:0] e_b;
  logic [5:0] e_br;

  task automatic model_reset();
    m_pc = 6'd0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
    m_last = '0;
    m_prev = '0;
    e_instr = K_NOP;
    e_a = 8'd0;
    e_b = 8'd0;
    e_br = 6'd0;
  endtask

  // Predict what the next rising edge issues, given current imem_valid.
  task automatic model_step();
    logic [15:0] w;
    logic [2:0]  op;
    logic [1:0]  rd, s1, s2;
    logic [7:0]  a, b;
    logic        dep;
    iss_t        nx;
    w  = mem[m_pc];
    op = w[15:13];
    rd = w[12:11];
    s1 = w[10:9];
    s2 = w[8:7];
    a  = 8'd0;
    b  = 8'd0;
    nx = '0;
    dep = op_writes(m_last.op) &&
          ((op_reads1(op) && s1 == m_last.rd) || (op_reads2(op) && s2 == m_last.rd));
    if (m_last.op == K_BR) begin
      if (m_prev.op == K_EQ && m_prev.res[0]) m_pc = m_last.tgt;
    end else if (imem_valid && !dep) begin
      if (op_reads1(op)) a = m_rf[s1];
      if (op_reads2(op)) b = m_rf[s2];
      nx.op  = op;
      nx.rd  = rd;
      nx.tgt = (op == K_BR) ? w[5:0] : 6'd0;
      nx.res = alu_f(op, a, b);
      if (op_writes(op)) m_rf[rd] = nx.res;
      m_pc = m_pc + 6'd1;
    end
    m_prev  = m_last;
    m_last  = nx;
    e_instr = nx.op;
    e_a     = a;
    e_b     = b;
    e_br    = nx.tgt;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc",     16'(imem_addr),   16'(m_pc));
      chk("instr",  16'(instr),       16'(e_instr));
      chk("A",      16'(A),           16'(e_a));
      chk("B",      16'(B),           16'(e_b));
      chk("br_addr",16'(branch_addr), 16'(e_br));
    end
  end

  task automatic lit_iss(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    chk({name, "_instr"}, 16'(instr), 16'(op));
    chk({name, "_A"},     16'(A),     16'(a));
    chk({name, "_B"},     16'(B),     16'(b));
  endtask

  // Hand-computed expectations after edge n of program ph.
  task automatic lit(input int ph, input int n);
    if (ph == 1) begin
      case (n)
        3:  lit_iss("p1_fwd_add", K_ADD, 8'h01, 8'h01);
        4:  begin lit_iss("p1_ilk_nop", K_NOP, 8'h00, 8'h00); chk("p1_ilk_pc", 16'(imem_addr), 16'd3); end
        9:  lit_iss("p1_add8", K_ADD, 8'h05, 8'h03);
        10: lit_iss("p1_nop", K_NOP, 8'h00, 8'h00);
        11: lit_iss("p1_sub_fwd", K_SUB, 8'h08, 8'h00);
        13: begin lit_iss("p1_and_bubble", K_NOP, 8'h00, 8'h00); chk("p1_and_pc", 16'(imem_addr), 16'd9); end
        14: lit_iss("p1_and", K_AND, 8'h10, 8'h03);
        15: lit_iss("p1_not", K_NOT, 8'h10, 8'h00);
        17: lit_iss("p1_or", K_OR, 8'hEF, 8'h00);
        18: begin chk("p1_br_instr", 16'(instr), 16'(K_BR)); chk("p1_br_tgt", 16'(branch_addr), 16'h20); end
        19: begin lit_iss("p1_br_nt", K_NOP, 8'h00, 8'h00); chk("p1_br_nt_pc", 16'(imem_addr), 16'd13); end
        24: begin chk("p1_stall_instr", 16'(instr), 16'(K_NOP)); chk("p1_stall_pc", 16'(imem_addr), 16'd15); end
        73: chk("p1_wrap_pc", 16'(imem_addr), 16'd0);
        default: ;
      endcase
    end else if (ph == 2) begin
      case (n)
        6:  begin chk("p2_br_instr", 16'(instr), 16'(K_BR)); chk("p2_br_pc", 16'(imem_addr), 16'd6); end
        7:  begin chk("p2_tk_instr", 16'(instr), 16'(K_NOP)); chk("p2_tk_pc", 16'(imem_addr), 16'h20); end
        8:  lit_iss("p2_eq_ne", K_EQ, 8'h01, 8'hFF);
        9:  chk("p2_br2_tgt", 16'(branch_addr), 16'h30);
        10: begin chk("p2_nt_instr", 16'(instr), 16'(K_NOP)); chk("p2_nt_pc", 16'(imem_addr), 16'h22); end
        default: ;
      endcase
    end else begin
      case (n)
        1:  lit_iss("p3_clr_add", K_ADD, 8'h00, 8'h00);
        3:  lit_iss("p3_clr_or", K_OR, 8'h00, 8'h00);
        default: ;
      endcase
    end
  endtask

  task automatic load_mem(input int ph);
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    if (ph == 1) begin
      mem[0]  = enc(K_EQ,  2'd1, 2'd0, 2'd0, 6'd0);
      mem[1]  = enc(K_NOP, 2'd0, 2'd1, 2'd1, 6'h3F) | 16'h0040;
      mem[2]  = enc(K_ADD, 2'd2, 2'd1, 2'd1, 6'd0);
      mem[3]  = enc(K_ADD, 2'd3, 2'd2, 2'd1, 6'd0);
      mem[4]  = enc(K_ADD, 2'd2, 2'd3, 2'd2, 6'd0);
      mem[5]  = enc(K_ADD, 2'd1, 2'd2, 2'd3, 6'd0);
      mem[7]  = enc(K_SUB, 2'd2, 2'd1, 2'd0, 6'd0);
      mem[8]  = enc(K_ADD, 2'd1, 2'd1, 2'd1, 6'd0);
      mem[9]  = enc(K_AND, 2'd2, 2'd1, 2'd3, 6'd0);
      mem[10] = enc(K_NOT, 2'd3, 2'd1, 2'd2, 6'd0);
      mem[11] = enc(K_OR,  2'd1, 2'd3, 2'd2, 6'd0);
      mem[12] = enc(K_BR,  2'd0, 2'd0, 2'd0, 6'h20) | 16'h0040;
    end else if (ph == 2) begin
      mem[0]     = enc(K_EQ,  2'd1, 2'd0, 2'd0, 6'd0);
      mem[2]     = enc(K_NOT, 2'd2, 2'd0, 2'd0, 6'd0);
      mem[4]     = enc(K_EQ,  2'd3, 2'd0, 2'd0, 6'd0);
      mem[5]     = enc(K_BR,  2'd0, 2'd0, 2'd0, 6'h20);
      mem[6]     = enc(K_NOT, 2'd3, 2'd2, 2'd0, 6'd0);
      mem[6'h20] = enc(K_EQ,  2'd3, 2'd1, 2'd2, 6'd0);
      mem[6'h21] = enc(K_BR,  2'd0, 2'd0, 2'd0, 6'h30);
      mem[6'h30] = enc(K_ADD, 2'd1, 2'd1, 2'd1, 6'd0);
    end else begin
      mem[0] = enc(K_ADD, 2'd0, 2'd1, 2'd2, 6'd0);
      mem[2] = enc(K_OR,  2'd1, 2'd3, 2'd2, 6'd0);
    end
  endtask

  // Async reset away from the clock edge; outputs must clear at once.
  task automatic do_reset(input int ph);
    RST_N = 1'b0;
    #1;
    chk("rst_instr", 16'(instr),       16'(K_NOP));
    chk("rst_A",     16'(A),           16'h0000);
    chk("rst_B",     16'(B),           16'h0000);
    chk("rst_br",    16'(branch_addr), 16'h0000);
    chk("rst_pc",    16'(imem_addr),   16'h0000);
    model_reset();
    load_mem(ph);
    chk_en = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic run(input int ph, input int nedges);
    for (int n = 1; n <= nedges; n++) begin
      imem_valid = !(ph == 1 && n >= 22 && n <= 24);
      model_step();
      @(posedge CLK);
      #1;
      lit(ph, n);
      @(negedge CLK);
      #1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    chk_en = 1'b0;
    imem_valid = 1'b0;
    RST_N = 1'b1;
    model_reset();
    load_mem(1);
    #1;
    do_reset(1);
    run(1, 100);
    do_reset(2);
    run(2, 12);
    do_reset(3);
    run(3, 5);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode and issue stage of the 8-bit pipelined CPU, directly upstream of the ALU. It holds the 6-bit program counter and the 4×8 register file, and fetches 16-bit instruction words. Each cycle it decodes one word into the ALU's `instr`/`A`/`B`/`branch_addr` inputs. ALU results come back into this stage for register writeback, operand forwarding and branch resolution. The stage also interlocks back-to-back register dependences.

## Interface
- `RESET_PC`, default 6'd0: PC value loaded on reset.
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `imem_addr`, output, 6: instruction address; combinationally equal to PC.
- `imem_data`, input, 16: instruction word at `imem_addr`, same cycle.
- `imem_valid`, input, 1: `imem_data` usable this cycle.
- `alu_out`, input, 8: registered ALU result.
- `branch_flag`, input, 1: ALU branch indicator; monitor only, not used for resolution.
- `A`, `B`, output, 8 each: registered operands to the ALU.
- `instr`, output, 3: registered opcode to the ALU.
- `branch_addr`, output, 6: registered branch target to the ALU.

## Operation
- Instruction word fields:
  - [15:13] opcode.
  - [12:11] rd.
  - [10:9] rs1.
  - [8:7] rs2.
  - [6] reserved, ignored.
  - [5:0] branch target.
- Opcode meanings and register use:
  - 000 NOP: no reads, no write.
  - 001 ADD, 010 SUB, 011 AND, 101 OR, 110 EQ: read rs1 and rs2, write rd.
  - 100 NOT: reads rs1 only; `B` is driven 0. Writes rd.
  - 111 BR: no reads, no write; target comes from [5:0].
- Issue registers: `instr`, `A`, `B`, `branch_addr`, plus internal `iss_rd`.
- Delay slot: `prv_op`/`prv_rd` hold the instruction issued one edge earlier. `alu_out` during the current cycle is that instruction's result.
- Writeback: at each edge where `prv_op` ∈ {001..110}, `rf[prv_rd] <= alu_out`.
- Forwarding: an operand read where rs == `prv_rd` and `prv_op` writes takes `alu_out`, not `rf`.
- Interlock: if a read rs == `iss_rd` and `instr` writes, issue a NOP and hold the PC.
- Branch resolution: in the edge after a BR issues (`instr`==111):
  - Taken = (`prv_op`==110) && `alu_out[0]`.
  - Issue a NOP.
  - If taken, PC <= `branch_addr`; otherwise PC holds, already pointing at BR+1.
  - This has priority over everything else.
- Normal issue: when `imem_valid` is high and no interlock or resolution applies, register the decoded word and set PC <= PC+1. The PC wraps 63→0.
- `imem_valid` low: issue a NOP and hold the PC.
- Every issued NOP sets `A`=`B`=0, `branch_addr`=0 and `instr`=000.

## Timing
- Reset (asynchronous, on `RST_N` low), all of the following:
  - PC=`RESET_PC`.
  - `instr`=000, `A`=`B`=0, `branch_addr`=0.
  - `prv_op`=000, `iss_rd`=0.
  - All registers 0.
- Reset mid-operation discards in-flight writeback and any pending branch.
- Issue latency: word present at edge k appears on the ALU inputs after edge k.
- Result availability: that instruction's result is on `alu_out` after edge k+1 and written to `rf` at edge k+2.
- Dependent instructions:
  - Distance 1: one stall bubble.
  - Distance 2: forwarded, no bubble.
  - Distance ≥3: read from `rf`.
- Branch penalty: exactly 1 bubble, taken or not.
- Simultaneous writeback and read of the same register at an edge: forwarding wins, so the new value is read.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode localparams OP_NOP…OP_BR.
  - Instruction field bit positions.
  - A `writes_rd(op)` and `reads_rs2(op)` helper function.
- Sub-module `reg_file`: 4×8, two async read ports, one sync write port, async active-low clear.

## Test plan
- Reset: assert `RST_N` mid-run → `instr`=000, `A`=`B`=0, `imem_addr`=`RESET_PC` immediately. All registers read 0 afterwards.
- Forwarding: ADD r1 (0x05+0x03 via preset regs), NOP, SUB r2=r1-r0 → the SUB issues `A`=0x08 with no bubble.
- Interlock: ADD r1, then AND r2=r1&r3 immediately → exactly one NOP between them. The AND issues `A`=ADD result, and the PC is held one cycle.
- Taken branch: EQ r0,r0 at addr 4, BR target 0x20 at addr 5 → one NOP, then `imem_addr`=0x20. The word at addr 6 is never issued.
- Not-taken branch: EQ with unequal operands, BR 0x20 → one NOP, then fetch from addr 6. BR not preceded by EQ is not taken.
- Stall and wrap: hold `imem_valid` low for 3 cycles → 3 NOPs with the PC held. Then run past addr 63 → `imem_addr` wraps to 0.
